// File: rtl/rpg_cmd_pkg.sv
// Command-word layout, command codes and ingress FSM encoding shared with the engine.
// CMD_REPEAT_EN adds the REPEAT state used to replay move commands.
package rpg_cmd_pkg;

    localparam logic [7:0] CMD_RIGHT    = 8'd1;
    localparam logic [7:0] CMD_LEFT     = 8'd2;
    localparam logic [7:0] CMD_UP       = 8'd3;
    localparam logic [7:0] CMD_DOWN     = 8'd4;
    localparam logic [7:0] CMD_ATTACK   = 8'd5;
    localparam logic [7:0] CMD_RUN      = 8'd6;
    localparam logic [7:0] CMD_NOSHROUD = 8'h10;

    localparam int CODE_LSB = 0;
    localparam int CODE_MSB = 7;
    localparam int RPT_LSB  = 8;
    localparam int RPT_MSB  = 15;

`ifdef CMD_REPEAT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_ISSUE, ST_REPEAT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_EVAL, ST_ISSUE} state_t;
`endif

    function automatic logic is_move(input logic [7:0] code);
        return (code >= CMD_RIGHT) && (code <= CMD_DOWN);
    endfunction

    // Mode screening of the code alone; the repeat field is judged by the caller.
    function automatic logic code_legal(input logic [7:0] code, input logic combat,
                                        input logic hacks);
        if (is_move(code))
            return !combat;
        if ((code == CMD_ATTACK) || (code == CMD_RUN))
            return combat;
        if (code == CMD_NOSHROUD)
            return hacks;
        return 1'b0;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/level come straight from the pointers.
module cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cmd_ingress.sv
// Command ingress: buffers raw player commands and offers only mode-legal ones to the engine.
// Define CMD_REPEAT_EN to let move commands carry a repeat count in bits [15:8].
module cmd_ingress
    import rpg_cmd_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [15:0]              in_cmd,
    output logic                     in_ready,
    input  logic                     in_combat,
    input  logic                     hacks_en,
    input  logic                     flush,
    output logic                     out_valid,
    output logic [7:0]               out_cmd,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         reject_cnt,
    output state_t                   fsm_state
);
    logic [15:0] head;
    logic [15:0] hold;
    logic [7:0]  hold_code;
    logic [7:0]  hold_rpt;
    logic        full;
    logic        empty;
    logic        pop;
    logic        legal;
    state_t      state;
`ifdef CMD_REPEAT_EN
    logic [7:0]  rpt_cnt;
`endif

    assign in_ready  = !full;
    assign pop       = (state == ST_IDLE) && !empty;
    assign hold_code = hold[CODE_MSB:CODE_LSB];
    assign hold_rpt  = hold[RPT_MSB:RPT_LSB];
    assign fsm_state = state;

    cmd_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (in_valid && in_ready),
        .din   (in_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        legal = code_legal(hold_code, in_combat, hacks_en);
`ifdef CMD_REPEAT_EN
        if (!is_move(hold_code) && (hold_rpt != 8'd0))
            legal = 1'b0;
`else
        if (hold_rpt != 8'd0)
            legal = 1'b0;
`endif
    end

    // out_valid/out_cmd are offered until a rising edge sees out_ready high; that edge is the
    // single transfer, and neither output changes while the engine holds out_ready low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold       <= '0;
            out_valid  <= 1'b0;
            out_cmd    <= '0;
            reject_cnt <= '0;
`ifdef CMD_REPEAT_EN
            rpt_cnt    <= '0;
`endif
        end else if (flush) begin
            state     <= ST_IDLE;
            hold      <= '0;
            out_valid <= 1'b0;
            out_cmd   <= '0;
`ifdef CMD_REPEAT_EN
            rpt_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        hold  <= head;
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (legal) begin
                        out_valid <= 1'b1;
                        out_cmd   <= hold_code;
                        state     <= ST_ISSUE;
`ifdef CMD_REPEAT_EN
                        rpt_cnt   <= is_move(hold_code) ? hold_rpt : 8'd0;
`endif
                    end else begin
                        if (reject_cnt != '1)
                            reject_cnt <= reject_cnt + CNT_W'(1);
                        state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
`ifdef CMD_REPEAT_EN
                        state     <= (rpt_cnt != 8'd0) ? ST_REPEAT : ST_IDLE;
`else
                        state     <= ST_IDLE;
`endif
                    end
                end
`ifdef CMD_REPEAT_EN
                ST_REPEAT: begin
                    // Entering combat mid-sequence abandons the rest; not a reject.
                    rpt_cnt <= rpt_cnt - 8'd1;
                    if (in_combat) begin
                        state <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_ingress.sv
// Directed and randomized checks of cmd_ingress against a rule-level command model.
// Repeat-field expectations follow CMD_REPEAT_EN when it is defined.
module tb_cmd_ingress;
    import rpg_cmd_pkg::*;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 8;
    localparam int TMO     = 3000;
    localparam int REJ_MAX = (1 << CNT_W) - 1;

    logic                   clk       = 1'b0;
    logic                   rst_n     = 1'b0;
    logic                   in_valid  = 1'b0;
    logic [15:0]            in_cmd    = '0;
    logic                   in_combat = 1'b0;
    logic                   hacks_en  = 1'b0;
    logic                   flush     = 1'b0;
    logic                   in_ready;
    logic                   out_valid;
    logic [7:0]             out_cmd;
    logic                   out_ready;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       reject_cnt;
    state_t                 fsm_state;

    logic [1:0]  ready_mode = 2'd0;
    logic        rnd_bit    = 1'b0;
    int          errors     = 0;
    int          checks     = 0;
    int          hs_count   = 0;
    int          exp_rej    = 0;
    logic [7:0]  exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign out_ready = (ready_mode == 2'd2) ? rnd_bit : ready_mode[0];

    cmd_ingress #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_cmd     (in_cmd),
        .in_ready   (in_ready),
        .in_combat  (in_combat),
        .hacks_en   (hacks_en),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_cmd    (out_cmd),
        .out_ready  (out_ready),
        .level      (level),
        .reject_cnt (reject_cnt),
        .fsm_state  (fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; any handshake about to happen is scored against the expected queue.
    task automatic tick();
        logic [7:0] e;
        @(negedge clk);
        if (rst_n && !flush && out_valid && out_ready) begin
            hs_count++;
            checks++;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            assert (out_cmd === e) else begin
                errors++;
                $error("FAIL issued_cmd: observed=%0h expected=%0h", out_cmd, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        int n = 0;
        in_cmd   = w;
        in_valid = 1'b1;
        while (!in_ready && n < TMO) begin
            tick();
            n++;
        end
        if (n >= TMO)
            chk("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < TMO) begin
            tick();
            n++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!(level == 0 && fsm_state == ST_IDLE && !out_valid) && n < TMO) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, 32'(n < TMO), 32'd1);
        chk({tag, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Reference: what the engine should see for one raw word under the current mode.
    task automatic model_word(input logic [15:0] w);
        int code = int'(w[7:0]);
        int r    = int'(w[15:8]);
        bit move = (code >= 1) && (code <= 4);
        bit ok;
        int copies;
        if (move)
            ok = !in_combat;
        else if (code == 5 || code == 6)
            ok = in_combat;
        else if (code == 16)
            ok = hacks_en;
        else
            ok = 1'b0;
`ifdef CMD_REPEAT_EN
        if (!move && r != 0)
            ok = 1'b0;
        copies = ok ? (move ? r + 1 : 1) : 0;
`else
        if (r != 0)
            ok = 1'b0;
        copies = ok ? 1 : 0;
`endif
        if (copies == 0)
            exp_rej = (exp_rej >= REJ_MAX) ? REJ_MAX : exp_rej + 1;
        else
            repeat (copies) exp_q.push_back(w[7:0]);
    endtask

    function automatic logic [15:0] gen_word();
        int sel = $urandom_range(0, 9);
        logic [7:0] code;
        logic [7:0] rpt;
        case (sel)
            0:       code = 8'd0;
            7:       code = CMD_NOSHROUD;
            8:       code = 8'd7;
            9:       code = 8'($urandom_range(17, 255));
            default: code = 8'(sel);
        endcase
        rpt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'd0;
        return {rpt, code};
    endfunction

    initial begin
        int hs0;
        int n;
        logic [15:0] w;

        // Reset values while held in reset
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_cmd", 32'(out_cmd), 32'd0);
        chk("rst_reject_cnt", 32'(reject_cnt), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        #2 rst_n = 1'b1;
        tick();

        // Latency from push edge E0 to out_valid
        push_word({8'd0, CMD_RIGHT});
        chk("lat_e0", 32'(out_valid), 32'd0);
        tick();
        chk("lat_e1", 32'(out_valid), 32'd0);
        tick();
        chk("lat_e2_valid", 32'(out_valid), 32'd1);
        chk("lat_e2_cmd", 32'(out_cmd), 32'(CMD_RIGHT));
        chk("lat_level", 32'(level), 32'd0);
        exp_q.push_back(CMD_RIGHT);
        hs0 = hs_count;
        ready_mode = 2'd1;
        tick();
        chk("lat_one_hs", 32'(hs_count - hs0), 32'd1);
        chk("lat_valid_drop", 32'(out_valid), 32'd0);

        // A mode change while offering does not retract the command
        ready_mode = 2'd0;
        push_word({8'd0, CMD_LEFT});
        wait_valid("hold_wait");
        in_combat = 1'b1;
        repeat (3) tick();
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_cmd", 32'(out_cmd), 32'(CMD_LEFT));
        exp_q.push_back(CMD_LEFT);
        ready_mode = 2'd1;
        drain("hold_drain");
        in_combat = 1'b0;

        // Illegal for the mode: attack out of combat, no-shroud without hacks
        hs0 = hs_count;
        push_word({8'd0, CMD_ATTACK});
        push_word({8'd0, CMD_NOSHROUD});
        chk("push_pop_level", 32'(level), 32'd1);
        exp_rej += 2;
        drain("rej_drain");
        chk("rej_cnt", 32'(reject_cnt), 32'(exp_rej));
        chk("rej_no_issue", 32'(hs_count - hs0), 32'd0);

        // Fill the queue behind a stalled command; the extra word waits
        ready_mode = 2'd0;
        push_word({8'd0, CMD_RIGHT});
        exp_q.push_back(CMD_RIGHT);
        wait_valid("full_wait");
        for (int i = 0; i < DEPTH; i++) begin
            w = 16'($urandom_range(1, 4));
            push_word(w);
            exp_q.push_back(w[7:0]);
        end
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_cmd   = {8'd0, CMD_DOWN};
        in_valid = 1'b1;
        repeat (3) tick();
        chk("held_in_ready", 32'(in_ready), 32'd0);
        chk("held_level", 32'(level), 32'(DEPTH));
        exp_q.push_back(CMD_DOWN);
        ready_mode = 2'd1;
        push_word({8'd0, CMD_DOWN});
        drain("full_drain");

`ifdef CMD_REPEAT_EN
        // Repeat field replays a move R+1 times
        hs0 = hs_count;
        push_word(16'h0203);
        repeat (3) exp_q.push_back(CMD_UP);
        drain("rpt_drain");
        chk("rpt_hs", 32'(hs_count - hs0), 32'd3);
        // Combat after the first issue abandons the rest without a reject
        ready_mode = 2'd0;
        push_word(16'h0203);
        wait_valid("rpt_abort_wait");
        exp_q.push_back(CMD_UP);
        hs0 = hs_count;
        ready_mode = 2'd1;
        n = 0;
        while (hs_count == hs0 && n < TMO) begin
            tick();
            n++;
        end
        in_combat = 1'b1;
        drain("rpt_abort_drain");
        chk("rpt_abort_hs", 32'(hs_count - hs0), 32'd1);
        chk("rpt_abort_rej", 32'(reject_cnt), 32'(exp_rej));
        in_combat = 1'b0;
`else
        // Any repeat count is rejected without the repeat feature
        hs0 = hs_count;
        push_word(16'h0203);
        exp_rej += 1;
        drain("rpt_rej_drain");
        chk("rpt_rej_hs", 32'(hs_count - hs0), 32'd0);
        chk("rpt_rej_cnt", 32'(reject_cnt), 32'(exp_rej));
`endif

        // Flush discards queue, held command and a same-cycle push
        ready_mode = 2'd0;
        for (int i = 1; i <= 4; i++)
            push_word(16'(i));
        wait_valid("flush_wait");
        flush    = 1'b1;
        in_valid = 1'b1;
        in_cmd   = {8'd0, CMD_RIGHT};
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_state", 32'(fsm_state), 32'(ST_IDLE));
        chk("flush_rej", 32'(reject_cnt), 32'(exp_rej));
        hs0 = hs_count;
        ready_mode = 2'd1;
        repeat (5) tick();
        chk("flush_no_issue", 32'(hs_count - hs0), 32'd0);
        chk("flush_level_late", 32'(level), 32'd0);

        // Randomized batches under a fixed mode per batch
        ready_mode = 2'd2;
        for (int b = 0; b < 24; b++) begin
            int nw;
            in_combat = 1'($urandom_range(0, 1));
            hacks_en  = 1'($urandom_range(0, 1));
            nw = $urandom_range(1, 6);
            for (int k = 0; k < nw; k++) begin
                w = gen_word();
                model_word(w);
                push_word(w);
                if ($urandom_range(0, 2) == 0)
                    tick();
            end
            drain("rand_drain");
            chk("rand_rej", 32'(reject_cnt), 32'(exp_rej));
        end

        // Reject counter saturates at all-ones
        in_combat  = 1'b0;
        hacks_en   = 1'b0;
        ready_mode = 2'd1;
        for (int i = 0; i < REJ_MAX + 5; i++) begin
            push_word(16'h0000);
            model_word(16'h0000);
        end
        drain("sat_drain");
        chk("rej_saturate", 32'(reject_cnt), 32'(exp_rej));

        // Asynchronous reset while a command is being offered
        ready_mode = 2'd0;
        push_word({8'd0, CMD_RIGHT});
        push_word({8'd0, CMD_LEFT});
        wait_valid("arst_wait");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cmd", 32'(out_cmd), 32'd0);
        chk("arst_level", 32'(level), 32'd0);
        chk("arst_rej", 32'(reject_cnt), 32'd0);
        exp_rej = 0;
        #2 rst_n = 1'b1;
        tick();
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_level_after", 32'(level), 32'd0);
        chk("arst_state", 32'(fsm_state), 32'(ST_IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmd_ingress.md
Name: cmd_ingress

Overview:
- Upstream stage of the dungeon engine. Accepts raw 16-bit player command words, buffers them in a FIFO, and screens each one against the engine's current mode (exploring vs. combat, cheats allowed).
- Issues legal commands one at a time over a valid/ready handshake; the engine consumes exactly one command per accepted handshake.
- Counts rejected commands. Replaces direct polling of the command file by the engine.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 8, width of the saturating reject counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  raw command present.
- in_cmd  in  16  raw command word; [7:0] = code, [15:8] = repeat field.
- in_ready  out  1  FIFO can accept; equals !full.
- in_combat  in  1  engine is on an enemy tile.
- hacks_en  in  1  cheat commands permitted.
- flush  in  1  synchronous: discard queue and any held command.
- out_valid  out  1  legal command offered to engine.
- out_cmd  out  8  command code (1 right, 2 left, 3 up, 4 down, 5 attack, 6 run, 0x10 no-shroud).
- out_ready  in  1  engine accepts out_cmd.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- reject_cnt  out  CNT_W  rejected commands; saturates at all-ones.

Behaviour:
- Reset (async on rst_n low): FIFO empty, level=0, in_ready=1, out_valid=0, out_cmd=0, reject_cnt=0, state IDLE.
- FIFO:
  - Push on in_valid & in_ready.
  - in_ready derives from the registered full flag, so no push occurs when full even if a pop happens in the same cycle.
  - Pointers carry an extra wrap bit; full/empty come from pointer compare.
- FSM, one decision per cycle:
  - IDLE: if !empty, pop head into the hold register and go to EVAL.
  - EVAL: classify the hold register using in_combat and hacks_en sampled this cycle.
    - Legal: go to ISSUE.
    - Illegal: reject_cnt++ (saturating), go to IDLE.
  - ISSUE: out_valid=1 and out_cmd is held stable until out_ready. On handshake go to IDLE, or to REPEAT if the optional feature applies.
- Legality rules:
  - Codes 1–4 are legal iff !in_combat.
  - Codes 5–6 are legal iff in_combat.
  - Code 0x10 is legal iff hacks_en.
  - Every other code, including 0, is illegal.
  - Without the optional feature, a nonzero repeat field is illegal.
- Latency: a word accepted at edge E0 into an empty queue with the FSM in IDLE gives out_valid high after edge E0+2. Sustained throughput is one command per 3 cycles.
- Simultaneous push and pop: both occur; level is unchanged.
- flush:
  - Clears the FIFO and the hold register, forces IDLE, and drops out_valid the next cycle.
  - A push in the same cycle as flush is discarded.
  - reject_cnt is kept.
- Mode changes while in ISSUE do not retract the offered command; legality is checked only in EVAL.

Optional Feature:
- Macro: CMD_REPEAT_EN.
- With the macro defined, the repeat field R applies to move codes 1–4 only: the command is issued R+1 times.
  - REPEAT state: decrement the remaining count, re-check in_combat, return to ISSUE.
  - If in_combat is 1 at the re-check, the remaining repeats are abandoned and the FSM goes to IDLE. This is not counted as a reject.
  - Nonzero R on a non-move code is illegal.
- Without the macro, any nonzero R is illegal, and the REPEAT state and repeat counter are absent.

Decomposition:
- Package rpg_cmd_pkg holds:
  - Command code constants: CMD_RIGHT=1, CMD_LEFT=2, CMD_UP=3, CMD_DOWN=4, CMD_ATTACK=5, CMD_RUN=6, CMD_NOSHROUD=8'h10.
  - FSM state encoding.
  - Field bit positions for code and repeat.
  - These constants are shared with the engine.
- Sub-module cmd_fifo: parameterised synchronous FIFO providing push, pop, flush, full, empty and level.

Test Plan:
- Reset mid-ISSUE with out_valid=1 → outputs return to reset values immediately; after rst_n rises, in_ready=1 and level=0.
- Push 0x0001, out_ready=1, in_combat=0 → out_valid after E0+2 with out_cmd=0x01; one handshake; level back to 0.
- Push 0x0005 with in_combat=0, then 0x0010 with hacks_en=0 → no out_valid; reject_cnt=2.
- Push DEPTH+1 words with out_ready=0 → in_ready=0 after DEPTH accepted, level=DEPTH; the extra word is held off, not lost.
- Push 0x0203 under CMD_REPEAT_EN → three handshakes with out_cmd=0x03. Raise in_combat after the first handshake → exactly one handshake, reject_cnt unchanged.
- Queue 4 commands, assert flush → level=0 and out_valid=0 next cycle; reject_cnt unchanged.
